// File: rtl/semaforo_pkg.sv
// Definitions shared by the pedestrian-crossing blocks: light codes, request
// FSM states and the default debounce length.
package semaforo_pkg;

    localparam logic [2:0] VERDE_C    = 3'b001;
    localparam logic [2:0] AMARELO_C  = 3'b010;
    localparam logic [2:0] VERMELHO_C = 3'b100;

    localparam logic [7:0] DEBOUNCE_PADRAO = 8'd3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        PEDIDO = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    // Saturating increment for the 8-bit served-request counter.
    function automatic logic [7:0] incr_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sincronizador_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; out is the
// accepted (debounced) level.
module sincronizador_debounce
    import semaforo_pkg::*;
#(
    parameter logic [7:0] DEBOUNCE = DEBOUNCE_PADRAO
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    // A DEBOUNCE of 0 is treated as 1, so the limit never underflows.
    localparam logic [7:0] LIMITE = (DEBOUNCE == 8'd0) ? 8'd0 : DEBOUNCE - 8'd1;

    logic       s1;
    logic       s2;
    logic       db;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= 8'd0;
        end else begin
            s1 <= in;
            s2 <= s1;
            if (s2 != db) begin
                if (cnt == LIMITE) begin
                    db  <= s2;
                    cnt <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

    assign out = db;

endmodule

// File: rtl/botao_condicionador.sv
// Pedestrian button conditioner: debounced press detect, one request pulse per
// press, requests blocked until light A has reached red.
module botao_condicionador
    import semaforo_pkg::*;
#(
    parameter logic [7:0] DEBOUNCE = DEBOUNCE_PADRAO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_raw,
    input  logic [2:0] A,
    output logic       bt,
    output logic       pendente,
    output logic [7:0] atendidos
);

    logic    db;
    logic    db_q;
    logic    press;
    logic    a_vermelho;
    estado_t estado;

    sincronizador_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sd (
        .clk (clk),
        .rst (rst),
        .in  (bt_raw),
        .out (db)
    );

    always_ff @(posedge clk) begin
        if (rst) db_q <= 1'b0;
        else     db_q <= db;
    end

    assign press      = db & ~db_q;
    // Only the exact red code counts; any other pattern (even invalid) is "not red".
    assign a_vermelho = (A == VERMELHO_C);

    // bt and pendente are registered alongside the state so they mirror it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            bt        <= 1'b0;
            pendente  <= 1'b0;
            atendidos <= 8'd0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (press && !a_vermelho) begin
                        estado   <= PEDIDO;
                        bt       <= 1'b1;
                        pendente <= 1'b1;
                    end
                end
                PEDIDO: begin
                    estado    <= ESPERA;
                    bt        <= 1'b0;
                    atendidos <= incr_sat(atendidos);
                end
                ESPERA: begin
                    if (a_vermelho) begin
                        estado   <= OCIOSO;
                        pendente <= 1'b0;
                    end
                end
                default: begin
                    estado   <= OCIOSO;
                    bt       <= 1'b0;
                    pendente <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_botao_condicionador.sv
// Directed bench for botao_condicionador with DEBOUNCE at its default of 3.
module tb_botao_condicionador;

    logic       clk = 1'b0;
    logic       rst;
    logic       bt_raw;
    logic [2:0] A;
    logic       bt;
    logic       pendente;
    logic [7:0] atendidos;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_at = 0;

    botao_condicionador dut (
        .clk       (clk),
        .rst       (rst),
        .bt_raw    (bt_raw),
        .A         (A),
        .bt        (bt),
        .pendente  (pendente),
        .atendidos (atendidos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds bt_raw high for 'width' edges inside an 'ncyc'-edge window and
    // records bt pulses, the tick index of the first pulse and pendente-high ticks.
    task automatic press_watch(input int width, input int ncyc, input bit red_on_bt,
                               output int pulses, output int first, output int pend);
        pulses = 0;
        first  = -1;
        pend   = 0;
        for (int i = 1; i <= ncyc; i++) begin
            bt_raw = (i <= width);
            tick();
            if (bt) begin
                pulses++;
                if (first < 0) first = i;
                if (red_on_bt) A = 3'b100;
            end
            if (pendente) pend++;
        end
        bt_raw = 1'b0;
    endtask

    task automatic serve();
        A = 3'b100;
        tick();
        A = 3'b001;
    endtask

    int p, f, pd, tot;
    logic [4:0] glitch;

    initial begin
        rst    = 1'b1;
        bt_raw = 1'b1;
        A      = 3'b001;

        // Reset with the button held
        tick();
        check("rst_bt_1", bt, 0);
        check("rst_pend_1", pendente, 0);
        tick();
        check("rst_bt_2", bt, 0);
        check("rst_pend_2", pendente, 0);
        check("rst_at", atendidos, 0);
        rst = 1'b0;
        press_watch(14, 14, 1'b0, p, f, pd);
        exp_at++;
        check("rst_pulses", p, 1);
        check("rst_first", f, 6);
        check("rst_pend", pd, 9);
        check("rst_at_after", atendidos, exp_at);
        A = 3'b100;
        tick();
        check("rst_served", pendente, 0);
        A = 3'b001;
        for (int i = 0; i < 8; i++) tick();

        // Clean press
        press_watch(6, 14, 1'b0, p, f, pd);
        exp_at++;
        check("clean_pulses", p, 1);
        check("clean_first", f, 6);
        check("clean_pend", pd, 9);
        check("clean_at", atendidos, exp_at);
        A = 3'b100;
        tick();
        check("clean_served", pendente, 0);
        A = 3'b001;

        // Glitchy press: 2 high, 1 low, 2 high
        glitch = 5'b11011;
        p = 0;
        for (int i = 0; i < 14; i++) begin
            bt_raw = (i < 5) ? glitch[4 - i] : 1'b0;
            tick();
            if (bt || pendente) p++;
        end
        check("glitch_pulses", p, 0);
        check("glitch_at", atendidos, exp_at);

        // Press while pending
        press_watch(5, 12, 1'b0, p, f, pd);
        exp_at++;
        check("pend1_pulses", p, 1);
        A = 3'b010;
        press_watch(5, 12, 1'b0, p, f, pd);
        check("pend2_pulses", p, 0);
        check("pend2_pend", pd, 12);
        check("pend2_at", atendidos, exp_at);
        serve();
        check("pend_served", pendente, 0);
        press_watch(5, 12, 1'b0, p, f, pd);
        exp_at++;
        check("pend3_pulses", p, 1);
        check("pend3_at", atendidos, exp_at);
        serve();

        // Press while red is dropped
        A = 3'b100;
        press_watch(5, 12, 1'b0, p, f, pd);
        check("red_pulses", p, 0);
        check("red_pend", pd, 0);
        check("red_at", atendidos, exp_at);
        A = 3'b001;

        // Non-one-hot A counts as not red
        A = 3'b110;
        press_watch(5, 12, 1'b0, p, f, pd);
        exp_at++;
        check("nonhot_pulses", p, 1);
        check("nonhot_first", f, 6);
        serve();

        // A goes red as the request is issued: pendente lasts 2 cycles
        press_watch(5, 12, 1'b1, p, f, pd);
        exp_at++;
        check("b2b_pulses", p, 1);
        check("b2b_pend", pd, 2);
        check("b2b_at", atendidos, exp_at);
        A = 3'b001;

        // Saturation
        tot = 0;
        for (int k = 0; k < 255; k++) begin
            press_watch(5, 12, 1'b0, p, f, pd);
            tot += p;
            if (exp_at < 255) exp_at++;
            serve();
        end
        check("sat_pulses", tot, 255);
        check("sat_at", atendidos, exp_at);
        check("sat_at_255", atendidos, 255);

        // Reset while in ESPERA
        press_watch(5, 8, 1'b0, p, f, pd);
        check("sat_more_pulse", p, 1);
        check("sat_hold", atendidos, 255);
        check("espera_pend", pendente, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_pend", pendente, 0);
        check("rst_mid_bt", bt, 0);
        check("rst_mid_at", atendidos, 0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
